// File: rtl/uart_tick_gen_if.sv
// Configuration channel of the UART tick generator: a new divisor
// (integer and fractional parts) offered with a valid/ready handshake.
interface uart_tick_gen_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic [DIV_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              cfg_valid;
    logic              cfg_ready;

    // Configuration source (CPU/register block side).
    modport master (
        output cfg_div_int,
        output cfg_div_frac,
        output cfg_valid,
        input  cfg_ready
    );

    // Tick generator side.
    modport slave (
        input  cfg_div_int,
        input  cfg_div_frac,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/uart_tick_gen.sv
// UART oversampling tick generator with a fractional, runtime-programmable
// divisor. Emits a sample tick every P clocks, a baud tick every OVS sample
// ticks and a mid-bit tick halfway through each bit. The sample/bit phase
// can be restarted from a start-bit edge, and a new divisor only takes
// effect at a bit boundary, while stopped, or on a resync.
module uart_tick_gen #(
    parameter int DIV_W   = 16,
    parameter int FRAC_W  = 4,
    parameter int OVS     = 8,
    parameter int RST_DIV = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   resync,
    uart_tick_gen_if.slave         cfg,
    output logic                   sample_tick,
    output logic                   baud_tick,
    output logic                   mid_tick,
    output logic [$clog2(OVS)-1:0] phase
);
    localparam int PH_W = $clog2(OVS);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(OVS - 1);
    localparam logic [PH_W-1:0]  PH_PRE_MID = PH_W'(OVS / 2 - 1);
    localparam logic [DIV_W:0]   CNT_ONE    = (DIV_W + 1)'(1);

    typedef struct packed {
        logic [DIV_W-1:0]  int_part;
        logic [FRAC_W-1:0] frac_part;
    } div_t;

    localparam div_t DIV_RESET = '{int_part: DIV_W'(RST_DIV), frac_part: '0};

    // cnt is one bit wider than the divisor so P = div_int + carry fits.
    logic [DIV_W:0]  cnt, cnt_nx;
    logic [FRAC_W-1:0] acc, acc_nx;
    logic            carry, carry_nx;
    logic [PH_W-1:0] phase_nx;
    div_t            div_act, div_act_nx;
    div_t            div_pend, div_pend_nx;
    logic            ready, ready_nx;
    logic            sample_nx, baud_nx, mid_nx;

    logic [DIV_W:0]  period;
    logic [FRAC_W:0] acc_sum;
    logic            due, at_last, apply;

    assign cfg.cfg_ready = ready;

    // Current period length, end-of-period detect and pending-divisor apply.
    always_comb begin
        period  = ((div_act.int_part == '0) ? CNT_ONE : {1'b0, div_act.int_part})
                  + {{DIV_W{1'b0}}, carry};
        // >= rather than == keeps the counter from running away if a
        // shorter divisor is applied while cnt is already past it.
        due     = (cnt >= period);
        at_last = (phase == PH_LAST);
        acc_sum = {1'b0, acc} + {1'b0, div_act.frac_part};
        // A pending divisor is only safe to switch in at a bit boundary,
        // while counting is frozen, or when the phase restarts anyway.
        apply   = !ready && (!en || resync || (due && at_last));
    end

    // Next-state logic for counter, accumulator, phase, ticks and config.
    always_comb begin
        // NOTE: every variable gets its hold/idle value first, so no path
        // through the branches below can leave one unassigned and infer a latch.
        cnt_nx      = cnt;
        acc_nx      = acc;
        carry_nx    = carry;
        phase_nx    = phase;
        div_act_nx  = div_act;
        div_pend_nx = div_pend;
        ready_nx    = ready;
        sample_nx   = 1'b0;
        baud_nx     = 1'b0;
        mid_nx      = 1'b0;

        if (en) begin
            if (resync) begin
                // Start-bit edge: restart a full period at sample 0 and drop
                // whatever tick was due this cycle.
                cnt_nx   = CNT_ONE;
                acc_nx   = '0;
                carry_nx = 1'b0;
                phase_nx = '0;
            end else if (due) begin
                cnt_nx    = CNT_ONE;
                acc_nx    = acc_sum[FRAC_W-1:0];
                carry_nx  = acc_sum[FRAC_W];
                sample_nx = 1'b1;
                baud_nx   = at_last;
                mid_nx    = (phase == PH_PRE_MID);
                phase_nx  = at_last ? '0 : phase + 1'b1;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end

        if (apply) begin
            div_act_nx = div_pend;
            acc_nx     = '0;
            carry_nx   = 1'b0;
            ready_nx   = 1'b1;
        end

        // Only one request can be outstanding; while busy the source holds.
        if (ready && cfg.cfg_valid) begin
            div_pend_nx = '{int_part: cfg.cfg_div_int, frac_part: cfg.cfg_div_frac};
            ready_nx    = 1'b0;
        end
    end

    // State and registered outputs; reset discards any pending divisor.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= CNT_ONE;
            acc         <= '0;
            carry       <= 1'b0;
            phase       <= '0;
            div_act     <= DIV_RESET;
            div_pend    <= '0;
            ready       <= 1'b1;
            sample_tick <= 1'b0;
            baud_tick   <= 1'b0;
            mid_tick    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register is computed from
            // pre-edge values regardless of statement order.
            cnt         <= cnt_nx;
            acc         <= acc_nx;
            carry       <= carry_nx;
            phase       <= phase_nx;
            div_act     <= div_act_nx;
            div_pend    <= div_pend_nx;
            ready       <= ready_nx;
            sample_tick <= sample_nx;
            baud_tick   <= baud_nx;
            mid_tick    <= mid_nx;
        end
    end
endmodule

// File: tb/tb_uart_tick_gen.sv
// Bench for uart_tick_gen: a period-index reference model checked every
// cycle, plus directed scenarios with hand-computed timing expectations.
module tb_uart_tick_gen;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 8;
    localparam int ST = 0, BT = 1, MT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       resync;
    logic       sample_tick, baud_tick, mid_tick;
    logic [2:0] phase;

    uart_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    uart_tick_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS), .RST_DIV(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .resync      (resync),
        .cfg         (bus),
        .sample_tick (sample_tick),
        .baud_tick   (baud_tick),
        .mid_tick    (mid_tick),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Period k after a clear lasts div + floor(k*f/2^FRAC_W) - floor((k-1)*f/2^FRAC_W).
    int m_el, m_k, m_n, m_div, m_frac, m_pint, m_pfrac;
    bit m_pend, m_ready, m_valid = 0;
    bit e_st, e_bt, e_mt;

    function automatic int extra(input int k, input int f);
        if (k == 0) return 0;
        return ((k * f) >> FRAC_W) - (((k - 1) * f) >> FRAC_W);
    endfunction

    task automatic model_step();
        bit apply_now, was_ready;
        int len;
        apply_now = 0;
        was_ready = m_ready;
        if (reset) begin
            m_el = 0; m_k = 0; m_n = 0; m_div = 5; m_frac = 0;
            m_pend = 0; m_ready = 1; e_st = 0; e_bt = 0; e_mt = 0;
        end else begin
            e_st = 0; e_bt = 0; e_mt = 0;
            if (!en) begin
                apply_now = m_pend;
            end else if (resync) begin
                m_el = 0; m_k = 0; m_n = 0;
                apply_now = m_pend;
            end else begin
                m_el++;
                len = ((m_div == 0) ? 1 : m_div) + extra(m_k, m_frac);
                if (m_el >= len) begin
                    e_st = 1;
                    e_bt = (m_n == OVS - 1);
                    e_mt = (m_n == OVS / 2 - 1);
                    m_n  = (m_n + 1) % OVS;
                    m_el = 0;
                    m_k++;
                    if (e_bt) apply_now = m_pend;
                end
            end
            if (apply_now) begin
                m_div = m_pint; m_frac = m_pfrac; m_k = 0; m_pend = 0; m_ready = 1;
            end
            if (was_ready && bus.cfg_valid) begin
                m_pend = 1; m_ready = 0;
                m_pint = int'(bus.cfg_div_int); m_pfrac = int'(bus.cfg_div_frac);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
        m_valid = 1;
    end

    // Compare process: outputs settle after the rising edge, checked on the falling one.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("model_sample_tick", int'(sample_tick), int'(e_st));
            check("model_baud_tick", int'(baud_tick), int'(e_bt));
            check("model_mid_tick", int'(mid_tick), int'(e_mt));
            check("model_phase", int'(phase), m_n);
            check("model_cfg_ready", int'(bus.cfg_ready), int'(m_ready));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sig(input int which);
        case (which)
            ST:      return sample_tick;
            BT:      return baud_tick;
            default: return mid_tick;
        endcase
    endfunction

    // Advance to the next negedge at which the chosen tick is high, within budget.
    task automatic wait_sig(input int which, input int budget, input string name);
        int  n;
        logic hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            hit = sig(which);
        end
        check({name, "_seen"}, int'(hit), 1);
    endtask

    initial begin
        int t0, t, tb0, tr, tg, n;
        int ts [0:17];

        reset = 1'b1; en = 1'b0; resync = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_div_int = '0; bus.cfg_div_frac = '0;
        cycles(4);
        check("rst_cfg_ready", int'(bus.cfg_ready), 1);
        check("rst_sample_tick", int'(sample_tick), 0);
        check("rst_phase", int'(phase), 0);

        // Defaults: P = 5, bit = 40 cycles, mid 20 cycles into the bit.
        reset = 1'b0; en = 1'b1; t0 = cyc;
        wait_sig(ST, 10, "first_tick");
        check("first_tick_latency", cyc - t0, 5);
        check("phase_after_first", int'(phase), 1);
        t = cyc;
        wait_sig(ST, 10, "second_tick");
        check("default_period", cyc - t, 5);
        wait_sig(MT, 50, "mid0");
        check("mid0_time", cyc - t0, 20);
        wait_sig(BT, 50, "baud0");
        tb0 = cyc;
        check("baud0_time", tb0 - t0, 40);
        wait_sig(MT, 50, "mid1");
        check("mid_after_baud", cyc - tb0, 20);
        wait_sig(BT, 50, "baud1");
        check("baud_period", cyc - tb0, 40);

        // Load 5 + 8/16 right at a bit boundary; applies at the next baud tick.
        bus.cfg_valid = 1'b1; bus.cfg_div_int = 16'd5; bus.cfg_div_frac = 4'd8;
        cycles(1);
        bus.cfg_valid = 1'b0;
        check("frac_ready_drop", int'(bus.cfg_ready), 0);
        wait_sig(BT, 60, "frac_apply_baud");
        check("frac_ready_back", int'(bus.cfg_ready), 1);
        ts[0] = cyc;
        for (int i = 1; i <= 17; i++) begin
            wait_sig(ST, 10, "frac_tick");
            ts[i] = cyc;
        end
        check("frac_period1", ts[1] - ts[0], 5);
        check("frac_period2", ts[2] - ts[1], 5);
        check("frac_period3", ts[3] - ts[2], 6);
        check("frac_period4", ts[4] - ts[3], 5);
        check("frac_period5", ts[5] - ts[4], 6);
        check("frac_span16", ts[17] - ts[1], 88);

        // Mid-bit request for 7.0; a second request while busy must be ignored.
        wait_sig(MT, 80, "midbit_mid");
        bus.cfg_valid = 1'b1; bus.cfg_div_int = 16'd7; bus.cfg_div_frac = 4'd0;
        cycles(1);
        check("midbit_ready_drop", int'(bus.cfg_ready), 0);
        bus.cfg_div_int = 16'd3;
        cycles(2);
        bus.cfg_valid = 1'b0;
        check("busy_ready_low", int'(bus.cfg_ready), 0);
        wait_sig(BT, 80, "midbit_baud");
        tb0 = cyc;
        check("midbit_ready_back", int'(bus.cfg_ready), 1);
        wait_sig(ST, 12, "new_period_tick1");
        check("new_period1", cyc - tb0, 7);
        t = cyc;
        wait_sig(ST, 12, "new_period_tick2");
        check("new_period2", cyc - t, 7);

        // Back to 5.0, applied by a one-cycle en drop.
        bus.cfg_valid = 1'b1; bus.cfg_div_int = 16'd5; bus.cfg_div_frac = 4'd0;
        cycles(1);
        bus.cfg_valid = 1'b0; en = 1'b0;
        cycles(1);
        en = 1'b1;
        check("en_apply_ready", int'(bus.cfg_ready), 1);

        // Resync exactly on the cycle a tick is due.
        wait_sig(ST, 20, "pre_resync");
        cycles(4);
        resync = 1'b1;
        cycles(1);
        resync = 1'b0;
        tr = cyc;
        check("resync_suppressed", int'(sample_tick), 0);
        check("resync_phase", int'(phase), 0);
        wait_sig(ST, 10, "post_resync");
        check("resync_next_tick", cyc - tr, 5);
        wait_sig(MT, 40, "resync_mid");
        check("resync_mid_time", cyc - tr, 20);

        // en low for 7 cycles with cnt = 3.
        wait_sig(ST, 10, "pre_gap");
        cycles(2);
        en = 1'b0;
        n = 0;
        repeat (7) begin
            @(negedge clk);
            if (sample_tick || baud_tick || mid_tick) n++;
        end
        check("gap_no_ticks", n, 0);
        en = 1'b1;
        tg = cyc;
        wait_sig(ST, 10, "post_gap");
        check("gap_resume", cyc - tg, 3);

        // Reset while a 9 + 3/16 request is pending.
        bus.cfg_valid = 1'b1; bus.cfg_div_int = 16'd9; bus.cfg_div_frac = 4'd3;
        cycles(1);
        bus.cfg_valid = 1'b0;
        check("pend_ready_low", int'(bus.cfg_ready), 0);
        reset = 1'b1;
        cycles(2);
        check("reset2_ready", int'(bus.cfg_ready), 1);
        check("reset2_sample_tick", int'(sample_tick), 0);
        check("reset2_phase", int'(phase), 0);
        reset = 1'b0;
        t0 = cyc;
        wait_sig(ST, 12, "reset2_tick1");
        check("reset2_first", cyc - t0, 5);
        t = cyc;
        wait_sig(ST, 12, "reset2_tick2");
        check("reset2_period", cyc - t, 5);

        cycles(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
